// File: rtl/add_word_sequencer.sv
// Multi-word adder sequencer: feeds an external 32-bit combinational adder one word per
// cycle (LSW first), chains carries, and returns the full-width sum over valid/ready.
//   state | meaning
//   IDLE  | ready for a new operand set
//   CALC  | one operand word per cycle through the adder
//   DONE  | result held on the output port until accepted
module add_word_sequencer #(
  parameter int WORDS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [32*WORDS-1:0]   in_a_i,
  input  logic [32*WORDS-1:0]   in_b_i,
  input  logic                  in_cin_i,
  output logic [31:0]           add_a_o,
  output logic [31:0]           add_b_o,
  output logic                  add_cin_o,
  input  logic [31:0]           add_sum_i,
  input  logic                  add_cout_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [32*WORDS-1:0]   out_sum_o,
  output logic                  out_cout_o
);

  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = in_a_i;
          b_d     = in_b_i;
          cin_d   = in_cin_i;
          idx_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d[32*int'(idx_q) +: 32] = add_sum_i;
        carry_d = add_cout_i;
        if (idx_q == IW'(WORDS - 1)) begin
          // Output registers load only here so out_* stay frozen outside DONE entry.
          out_sum_d  = acc_d;
          out_cout_d = add_cout_i;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    out_sum_o   = out_sum_q;
    out_cout_o  = out_cout_q;
    add_a_o     = '0;
    add_b_o     = '0;
    add_cin_o   = 1'b0;
    if (state_q == CALC) begin
      add_a_o   = a_q[32*int'(idx_q) +: 32];
      add_b_o   = b_q[32*int'(idx_q) +: 32];
      add_cin_o = (idx_q == '0) ? cin_q : carry_q;
    end
  end

endmodule
